// File: rtl/overflow_fifo_reader_if.sv
// Bus bundle between overflow_fifo_reader, the overflow FIFO head it drains
// and the readout-mux sink it feeds. master = reader, slave = FIFO + sink side.
interface overflow_fifo_reader_if #(
    parameter int P_LTC_WIDTH = 49
) ();

    logic [15:0]            overflow_fifo_count;
    logic [P_LTC_WIDTH-1:0] overflow_start_ltc;
    logic [P_LTC_WIDTH-1:0] overflow_end_ltc;
    logic [4:0]             channel_index;
    logic                   overflow_fifo_rdreq;
    logic [15:0]            dout;
    logic                   dout_valid;
    logic                   dout_last;
    logic                   dout_ready;

    modport master (
        input  overflow_fifo_count,
        input  overflow_start_ltc,
        input  overflow_end_ltc,
        input  channel_index,
        output overflow_fifo_rdreq,
        output dout,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        output overflow_fifo_count,
        output overflow_start_ltc,
        output overflow_end_ltc,
        output channel_index,
        input  overflow_fifo_rdreq,
        input  dout,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );

endinterface

// File: rtl/overflow_fifo_reader.sv
// Pops overflow records (channel, start LTC, end LTC) and streams each as a fixed
// 16-bit word burst. Define OVFLW_RD_CHECKSUM_EN to append an XOR checksum word.
module overflow_fifo_reader #(
    parameter int         P_LTC_WIDTH = 49,
    parameter int         P_FIFO_LAT  = 2,
    parameter logic [7:0] P_HDR_TAG   = 8'hE0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    overflow_fifo_reader_if.master        bus,
    output logic                          busy,
    output logic [31:0]                   n_records
);

`ifdef OVFLW_RD_CHECKSUM_EN
    localparam int NUM_WORDS = 11;
`else
    localparam int NUM_WORDS = 10;
`endif
    localparam logic [3:0] LAST_IDX  = 4'(NUM_WORDS - 1);
    localparam logic [2:0] WAIT_LOAD = 3'(P_FIFO_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  word_idx_r, word_idx_s;
    logic [2:0]  wait_cnt_r, wait_cnt_s;
    logic [4:0]  chan_r, chan_s;
    logic [63:0] start_r, start_s;
    logic [63:0] end_r, end_s;
    logic [15:0] dur_r, dur_s;
    logic        rdreq_r, rdreq_s;
    logic [15:0] dout_r, dout_s;
    logic        dout_valid_r, dout_valid_s;
    logic        dout_last_r, dout_last_s;
    logic        busy_r, busy_s;
    logic [31:0] n_records_r, n_records_s;

    logic [P_LTC_WIDTH-1:0] diff_s;
    logic [3:0]             idx_inc_s;

    // Modulo subtraction in the LTC width gives the wrap-safe duration.
    assign diff_s    = bus.overflow_end_ltc - bus.overflow_start_ltc;
    assign idx_inc_s = word_idx_r + 4'd1;

    function automatic logic [15:0] sat_duration(input logic [63:0] d);
        return (d >= 64'd65535) ? 16'hFFFF : d[15:0];
    endfunction

`ifdef OVFLW_RD_CHECKSUM_EN
    function automatic logic [15:0] record_checksum(
        input logic [4:0]  chan,
        input logic [63:0] s,
        input logic [63:0] e,
        input logic [15:0] dur
    );
        return {P_HDR_TAG, 3'b000, chan}
             ^ s[63:48] ^ s[47:32] ^ s[31:16] ^ s[15:0]
             ^ e[63:48] ^ e[47:32] ^ e[31:16] ^ e[15:0]
             ^ dur;
    endfunction
`endif

    function automatic logic [15:0] record_word(
        input logic [3:0]  idx,
        input logic [4:0]  chan,
        input logic [63:0] s,
        input logic [63:0] e,
        input logic [15:0] dur
    );
        logic [15:0] w;
        case (idx)
            4'd0:    w = {P_HDR_TAG, 3'b000, chan};
            4'd1:    w = s[63:48];
            4'd2:    w = s[47:32];
            4'd3:    w = s[31:16];
            4'd4:    w = s[15:0];
            4'd5:    w = e[63:48];
            4'd6:    w = e[47:32];
            4'd7:    w = e[31:16];
            4'd8:    w = e[15:0];
            4'd9:    w = dur;
`ifdef OVFLW_RD_CHECKSUM_EN
            4'd10:   w = record_checksum(chan, s, e, dur);
`endif
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_s      = state_r;
        word_idx_s   = word_idx_r;
        wait_cnt_s   = wait_cnt_r;
        chan_s       = chan_r;
        start_s      = start_r;
        end_s        = end_r;
        dur_s        = dur_r;
        rdreq_s      = 1'b0;
        dout_s       = dout_r;
        dout_valid_s = dout_valid_r;
        dout_last_s  = dout_last_r;
        n_records_s  = n_records_r;

        case (state_r)
            ST_IDLE: begin
                if (enable && (bus.overflow_fifo_count != 16'd0)) begin
                    state_s = ST_LATCH;
                    rdreq_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                // FWFT head is still valid in the pop cycle, so capture it here.
                chan_s       = bus.channel_index;
                start_s      = 64'(bus.overflow_start_ltc);
                end_s        = 64'(bus.overflow_end_ltc);
                dur_s        = sat_duration(64'(diff_s));
                dout_s       = record_word(4'd0, bus.channel_index, 64'd0, 64'd0, 16'd0);
                dout_valid_s = 1'b1;
                dout_last_s  = 1'b0;
                word_idx_s   = 4'd0;
                state_s      = ST_SEND;
            end
            ST_SEND: begin
                if (dout_valid_r && bus.dout_ready) begin
                    if (word_idx_r == LAST_IDX) begin
                        dout_s       = 16'h0000;
                        dout_valid_s = 1'b0;
                        dout_last_s  = 1'b0;
                        n_records_s  = n_records_r + 32'd1;
                        wait_cnt_s   = WAIT_LOAD;
                        state_s      = ST_WAIT;
                    end else begin
                        word_idx_s  = idx_inc_s;
                        dout_s      = record_word(idx_inc_s, chan_r, start_r, end_r, dur_r);
                        dout_last_s = (idx_inc_s == LAST_IDX);
                    end
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                // Give the FIFO count time to reflect the pop before re-arming.
                if (wait_cnt_r == 3'd0) begin
                    state_s = ST_IDLE;
                end else begin
                    wait_cnt_s = wait_cnt_r - 3'd1;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                dout_s       = 16'h0000;
                dout_valid_s = 1'b0;
                dout_last_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            word_idx_r   <= 4'd0;
            wait_cnt_r   <= 3'd0;
            chan_r       <= 5'd0;
            start_r      <= 64'd0;
            end_r        <= 64'd0;
            dur_r        <= 16'd0;
            rdreq_r      <= 1'b0;
            dout_r       <= 16'h0000;
            dout_valid_r <= 1'b0;
            dout_last_r  <= 1'b0;
            busy_r       <= 1'b0;
            n_records_r  <= 32'd0;
        end else begin
            state_r      <= state_s;
            word_idx_r   <= word_idx_s;
            wait_cnt_r   <= wait_cnt_s;
            chan_r       <= chan_s;
            start_r      <= start_s;
            end_r        <= end_s;
            dur_r        <= dur_s;
            rdreq_r      <= rdreq_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            dout_last_r  <= dout_last_s;
            busy_r       <= busy_s;
            n_records_r  <= n_records_s;
        end
    end

    assign bus.overflow_fifo_rdreq = rdreq_r;
    assign bus.dout                = dout_r;
    assign bus.dout_valid          = dout_valid_r;
    assign bus.dout_last           = dout_last_r;
    assign busy                    = busy_r;
    assign n_records               = n_records_r;

endmodule

// File: tb/tb_overflow_fifo_reader.sv
// Self-checking bench for overflow_fifo_reader: queue-based FIFO model and a
// record-level word model built straight from the record format rules.
module tb_overflow_fifo_reader;

`ifdef OVFLW_RD_CHECKSUM_EN
    localparam int NW = 11;
`else
    localparam int NW = 10;
`endif
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [31:0] n_records;

    overflow_fifo_reader_if #(.P_LTC_WIDTH(49)) bus ();

    overflow_fifo_reader #(
        .P_LTC_WIDTH (49),
        .P_FIFO_LAT  (LAT),
        .P_HDR_TAG   (8'hE0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bus       (bus),
        .busy      (busy),
        .n_records (n_records)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int rdreq_cnt = 0;
    int n_exp  = 0;

    logic [4:0]  fifo_chan[$];
    logic [48:0] fifo_start[$];
    logic [48:0] fifo_end[$];
    int          pop_cyc_q[$];
    logic [15:0] got_q[$];
    logic        got_last_q[$];
    logic [15:0] exp_q[$];
    logic        exp_last_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        bus.overflow_fifo_count = 16'(fifo_chan.size());
        if (fifo_chan.size() > 0) begin
            bus.channel_index      = fifo_chan[0];
            bus.overflow_start_ltc = fifo_start[0];
            bus.overflow_end_ltc   = fifo_end[0];
        end
    endtask

    // Expected words: header, start/end as 64-bit MSW-first, saturated modular duration, optional XOR.
    task automatic push_record(input logic [4:0] c, input logic [48:0] s, input logic [48:0] e);
        longint unsigned m, su, eu, d;
        logic [15:0] w[0:10];
        logic [15:0] x;
        m  = 64'd1 << 49;
        su = 64'(s);
        eu = 64'(e);
        d  = (eu + m - su) % m;
        w[0] = {8'hE0, 3'b000, c};
        for (int k = 0; k < 4; k++) begin
            w[1 + k] = 16'((su >> (48 - 16 * k)) & 64'hFFFF);
            w[5 + k] = 16'((eu >> (48 - 16 * k)) & 64'hFFFF);
        end
        w[9] = (d >= 64'd65535) ? 16'hFFFF : 16'(d);
        x = 16'h0000;
        for (int k = 0; k < 10; k++) x = x ^ w[k];
        w[10] = x;
        for (int k = 0; k < NW; k++) begin
            exp_q.push_back(w[k]);
            exp_last_q.push_back(k == NW - 1);
        end
        fifo_chan.push_back(c);
        fifo_start.push_back(s);
        fifo_end.push_back(e);
        refresh();
    endtask

    // One clock: record what the DUT shows this cycle, advance, then model the pop.
    task automatic tick();
        logic pop;
        pop = bus.overflow_fifo_rdreq;
        if (bus.dout_valid && bus.dout_ready) begin
            got_q.push_back(bus.dout);
            got_last_q.push_back(bus.dout_last);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            rdreq_cnt++;
            pop_cyc_q.push_back(cyc);
            if (fifo_chan.size() > 0) begin
                void'(fifo_chan.pop_front());
                void'(fifo_start.pop_front());
                void'(fifo_end.pop_front());
            end
        end
        refresh();
    endtask

    task automatic drain(input int max_cycles, input bit stall, input bit idle_only);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            bus.dout_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            if (!busy && (idle_only || fifo_chan.size() == 0)) done = 1'b1;
        end
        bus.dout_ready = 1'b1;
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic run_to_word(input int idx, input int max_cycles);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (got_q.size() == idx && bus.dout_valid) found = 1'b1;
        end
        check("reach_word", 64'(found), 64'd1);
    endtask

    task automatic compare_stream(input int n);
        check("stream_len", 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
                check($sformatf("last%0d", i), 64'(got_last_q[i]), 64'(exp_last_q[i]));
            end
        end
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
    endtask

    initial begin
        int base_rd;
        logic [48:0] s, e;

        rst = 1'b1;
        enable = 1'b0;
        bus.dout_ready = 1'b1;
        bus.overflow_fifo_count = 16'd0;
        bus.overflow_start_ltc = 49'd0;
        bus.overflow_end_ltc = 49'd0;
        bus.channel_index = 5'd0;
        repeat (3) tick();
        check("rst_rdreq", 64'(bus.overflow_fifo_rdreq), 64'd0);
        check("rst_dout", 64'(bus.dout), 64'd0);
        check("rst_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_last", 64'(bus.dout_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_nrec", 64'(n_records), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Single record with latency and exact word values.
        enable = 1'b1;
        base_rd = rdreq_cnt;
        push_record(5'd3, 49'h1_0000_0000_1234, 49'h1_0000_0000_1234 + 49'd100);
        tick();
        check("lat_rdreq", 64'(bus.overflow_fifo_rdreq), 64'd1);
        check("lat_valid_early", 64'(bus.dout_valid), 64'd0);
        tick();
        check("lat_valid", 64'(bus.dout_valid), 64'd1);
        check("lat_w0", 64'(bus.dout), 64'hE003);
        check("lat_rdreq_off", 64'(bus.overflow_fifo_rdreq), 64'd0);
        drain(200, 1'b0, 1'b0);
        if (got_q.size() >= 10) begin
            check("t1_w1", 64'(got_q[1]), 64'h0001);
            check("t1_w2", 64'(got_q[2]), 64'h0000);
            check("t1_w3", 64'(got_q[3]), 64'h0000);
            check("t1_w4", 64'(got_q[4]), 64'h1234);
            check("t1_w9", 64'(got_q[9]), 64'd100);
        end
        compare_stream(NW);
        n_exp += 1;
        check("t1_rdreq_pulses", 64'(rdreq_cnt - base_rd), 64'd1);
        check("t1_nrec", 64'(n_records), 64'(n_exp));

        // Duration saturation and modulo wrap.
        push_record(5'd7, 49'd10, 49'd70010);
        push_record(5'd8, 49'h1_FFFF_FFFF_FFFF, 49'd5);
        drain(400, 1'b0, 1'b0);
        if (got_q.size() >= 2 * NW) begin
            check("sat_w9", 64'(got_q[9]), 64'hFFFF);
            check("mod_w9", 64'(got_q[NW + 9]), 64'd6);
        end
        compare_stream(2 * NW);
        n_exp += 2;
        check("sat_nrec", 64'(n_records), 64'(n_exp));

        // Back-pressure: hold ready low for 3 cycles while W4 is presented.
        push_record(5'd12, 49'h0_1234_5678_9ABC, 49'h0_1234_5679_0000);
        run_to_word(4, 100);
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_valid", 64'(bus.dout_valid), 64'd1);
            check("bp_w4_hold", 64'(bus.dout), 64'(exp_q[4]));
            check("bp_last_low", 64'(bus.dout_last), 64'd0);
        end
        drain(200, 1'b0, 1'b0);
        compare_stream(NW);
        n_exp += 1;
        check("bp_nrec", 64'(n_records), 64'(n_exp));

        // Back-to-back records.
        base_rd = rdreq_cnt;
        pop_cyc_q.delete();
        push_record(5'd0, 49'h0_0000_0001_0000, 49'h0_0000_0001_0100);
        push_record(5'd23, 49'h1_5555_AAAA_0000, 49'h1_5555_AAAA_0040);
        drain(400, 1'b0, 1'b0);
        check("b2b_pulses", 64'(rdreq_cnt - base_rd), 64'd2);
        if (pop_cyc_q.size() == 2)
            check("b2b_gap", 64'(pop_cyc_q[1] - pop_cyc_q[0] >= 10 + LAT + 1), 64'd1);
        compare_stream(2 * NW);
        n_exp += 2;
        check("b2b_nrec", 64'(n_records), 64'(n_exp));

        // Randomized records with random ready stalls.
        for (int r = 0; r < 6; r++) begin
            s = 49'({$urandom(), $urandom()});
            if ($urandom_range(0, 1) == 1) e = s + 49'($urandom_range(0, 100000));
            else e = 49'({$urandom(), $urandom()});
            push_record(5'($urandom_range(0, 31)), s, e);
        end
        drain(3000, 1'b1, 1'b0);
        compare_stream(6 * NW);
        n_exp += 6;
        check("rnd_nrec", 64'(n_records), 64'(n_exp));

        // Enable drop mid-record, then reset mid-record.
        base_rd = rdreq_cnt;
        push_record(5'd5, 49'd1000, 49'd2000);
        push_record(5'd6, 49'd3000, 49'd4000);
        run_to_word(2, 100);
        enable = 1'b0;
        drain(200, 1'b0, 1'b1);
        repeat (10) tick();
        check("en_pulses", 64'(rdreq_cnt - base_rd), 64'd1);
        check("en_fifo_left", 64'(fifo_chan.size()), 64'd1);
        check("en_busy", 64'(busy), 64'd0);
        compare_stream(NW);
        n_exp += 1;
        check("en_nrec", 64'(n_records), 64'(n_exp));
        enable = 1'b1;
        run_to_word(5, 100);
        rst = 1'b1;
        tick();
        check("rst_mid_valid", 64'(bus.dout_valid), 64'd0);
        check("rst_mid_nrec", 64'(n_records), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_dout", 64'(bus.dout), 64'd0);
        rst = 1'b0;
        enable = 1'b0;
        got_q.delete();
        got_last_q.delete();
        exp_q.delete();
        exp_last_q.delete();
        tick();
        check("rst_fifo_popped", 64'(fifo_chan.size()), 64'd0);
        check("rst_after_rdreq", 64'(bus.overflow_fifo_rdreq), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
